// File: rtl/noc_flit_router_port_pkg.sv
// Shared constants, flit field offsets and types for the NoC router ingress port.
package noc_pkg;

  localparam logic [5:0]  HEADER_TAG = 6'b101111;
  localparam logic [7:0]  TAIL_FLIT  = 8'hFF;
  localparam int unsigned MAX_DATA   = 4;

  localparam int unsigned TAG_HI  = 7;
  localparam int unsigned TAG_LO  = 2;
  localparam int unsigned DEST_HI = 1;
  localparam int unsigned DEST_LO = 0;

  typedef enum logic [1:0] {
    P_HEAD = 2'd0,
    P_DATA = 2'd1,
    P_TAIL = 2'd2,
    P_DROP = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic       last;
    logic [1:0] dest;
    logic [7:0] flit;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/noc_flit_router_port_if.sv
// Flit link between the NI (master) and the router port (slave), plus local egress.
interface noc_flit_router_port_if;
  logic [7:0] flit_in;
  logic       flit_in_valid;
  logic       noc_ready;
  logic [7:0] flit_out;
  logic [3:0] flit_out_valid;
  logic [3:0] dest_ready;

  modport master (
    output flit_in, flit_in_valid, dest_ready,
    input  noc_ready, flit_out, flit_out_valid
  );

  modport slave (
    input  flit_in, flit_in_valid, dest_ready,
    output noc_ready, flit_out, flit_out_valid
  );
endinterface

// File: rtl/noc_flit_router_port_fifo.sv
// Show-ahead synchronous FIFO; a separate occupancy counter resolves full vs empty.
module noc_flit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/noc_flit_router_port.sv
// Router-side flit link endpoint: framing parser, elastic buffer and one-hot local egress.
module noc_flit_router_port
  import noc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [5:0]  HEADER_TAG = noc_pkg::HEADER_TAG,
  parameter logic [7:0]  TAIL_FLIT  = noc_pkg::TAIL_FLIT,
  parameter int unsigned MAX_DATA   = noc_pkg::MAX_DATA,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_flit_router_port_if.slave link,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      err_cnt
);
  localparam int unsigned DW = $clog2(MAX_DATA + 1);

  parse_state_t state, state_next;
  logic [DW-1:0] dcnt, dcnt_next;
  logic [1:0]    dest, dest_next;
  logic          xfer;
  logic          push;
  entry_t        push_entry;
  logic          err_inc;
  entry_t        head;
  logic          full;
  logic          empty;
  logic          pop;

  assign link.noc_ready = ~full;
  assign xfer           = link.flit_in_valid & link.noc_ready;

  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    dest_next  = dest;
    push       = 1'b0;
    push_entry = '0;
    err_inc    = 1'b0;
    if (xfer) begin
      unique case (state)
        P_HEAD: begin
          if (link.flit_in[TAG_HI:TAG_LO] == HEADER_TAG) begin
            dest_next  = link.flit_in[DEST_HI:DEST_LO];
            push       = 1'b1;
            push_entry = '{last: 1'b0, dest: link.flit_in[DEST_HI:DEST_LO], flit: link.flit_in};
            dcnt_next  = '0;
            state_next = P_DATA;
          end else begin
            err_inc    = 1'b1;
            state_next = P_DROP;
          end
        end
        // dcnt never reaches MAX_DATA here, so a nonzero count means a tail is allowed.
        P_DATA: begin
          push = 1'b1;
          if (dcnt != '0 && link.flit_in == TAIL_FLIT) begin
            push_entry = '{last: 1'b1, dest: dest, flit: link.flit_in};
            state_next = P_HEAD;
          end else begin
            push_entry = '{last: 1'b0, dest: dest, flit: link.flit_in};
            dcnt_next  = dcnt + 1'b1;
            if (dcnt_next == DW'(MAX_DATA)) state_next = P_TAIL;
          end
        end
        P_TAIL: begin
          push       = 1'b1;
          push_entry = '{last: 1'b1, dest: dest, flit: link.flit_in};
          err_inc    = (link.flit_in != TAIL_FLIT);
          state_next = P_HEAD;
        end
        P_DROP: begin
          if (link.flit_in == TAIL_FLIT) state_next = P_HEAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= P_HEAD;
      dcnt  <= '0;
      dest  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
      dest  <= dest_next;
    end
  end

  noc_flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Output is forced to zero while empty so stale RAM contents never leak out.
  assign link.flit_out       = empty ? '0 : head.flit;
  assign link.flit_out_valid = empty ? '0 : (4'b0001 << head.dest);
  assign pop                 = |(link.flit_out_valid & link.dest_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pop && head.last && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
      if (err_inc && err_cnt != '1)          err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_flit_router_port.sv
// Scoreboard bench for noc_flit_router_port: directed packets, queued expectations, egress monitor.
module tb_noc_flit_router_port;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] flit;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pkt_cnt;
  logic [7:0] err_cnt;
  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q[$];

  noc_flit_router_port_if link ();

  noc_flit_router_port #(
    .FIFO_DEPTH (8),
    .HEADER_TAG (6'b101111),
    .TAIL_FLIT  (8'hFF),
    .MAX_DATA   (4),
    .CNT_W      (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .link    (link.slave),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_flit(input logic [1:0] p, input logic [7:0] f);
    exp_q.push_back('{port: p, flit: f});
  endtask

  task automatic send(input logic [7:0] f);
    int unsigned n = 0;
    logic acc;
    link.flit_in       = f;
    link.flit_in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = link.noc_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: flit %0h never accepted", f);
    end
    link.flit_in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d flits still expected", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("egress_idle", {28'd0, link.flit_out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Egress monitor: every transfer must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (link.flit_out_valid & link.dest_ready) != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL egress_unexpected: valid %b flit %0h with nothing expected",
                   link.flit_out_valid, link.flit_out);
        end else begin
          e = exp_q.pop_front();
          if (link.flit_out_valid !== (4'b0001 << e.port) || link.flit_out !== e.flit) begin
            errors++;
            $display("FAIL egress_flit: got valid %b flit %0h expected valid %b flit %0h",
                     link.flit_out_valid, link.flit_out, 4'b0001 << e.port, e.flit);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    link.flit_in       = 8'h00;
    link.flit_in_valid = 1'b0;
    link.dest_ready    = 4'hF;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {28'd0, link.flit_out_valid}, 32'd0);
    check("rst_flit", {24'd0, link.flit_out}, 32'd0);
    check("rst_ready", {31'd0, link.noc_ready}, 32'd1);
    check("rst_pkt", {24'd0, pkt_cnt}, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;

    // 1: full-length packet to port 2
    expect_flit(2, 8'hBE); expect_flit(2, 8'h11); expect_flit(2, 8'h22);
    expect_flit(2, 8'h33); expect_flit(2, 8'h44); expect_flit(2, 8'hFF);
    send(8'hBE); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'hFF);
    drain();
    check("t1_pkt", {24'd0, pkt_cnt}, 32'd1);
    check("t1_err", {24'd0, err_cnt}, 32'd0);

    // 2: short packet to port 1, then first-data 0xFF to port 0
    expect_flit(1, 8'hBD); expect_flit(1, 8'h55); expect_flit(1, 8'hFF);
    send(8'hBD); send(8'h55); send(8'hFF);
    expect_flit(0, 8'hBC); expect_flit(0, 8'hFF); expect_flit(0, 8'hAA); expect_flit(0, 8'hFF);
    send(8'hBC); send(8'hFF); send(8'hAA); send(8'hFF);
    drain();
    check("t2_pkt", {24'd0, pkt_cnt}, 32'd3);
    check("t2_err", {24'd0, err_cnt}, 32'd0);

    // 3: bad header is dropped up to its tail, next packet routes
    send(8'h3C); send(8'h12); send(8'h34); send(8'hFF);
    drain();
    check("t3_err", {24'd0, err_cnt}, 32'd1);
    check("t3_pkt", {24'd0, pkt_cnt}, 32'd3);
    expect_flit(1, 8'hBD); expect_flit(1, 8'h77); expect_flit(1, 8'hFF);
    send(8'hBD); send(8'h77); send(8'hFF);
    drain();
    check("t3_pkt_after", {24'd0, pkt_cnt}, 32'd4);

    // 4: back-pressure fills the FIFO; the 9th flit waits until a pop frees space
    link.dest_ready = 4'h0;
    expect_flit(2, 8'hBE); expect_flit(2, 8'h01); expect_flit(2, 8'h02);
    expect_flit(2, 8'h03); expect_flit(2, 8'h04); expect_flit(2, 8'hFF);
    expect_flit(1, 8'hBD); expect_flit(1, 8'h05); expect_flit(1, 8'hFF);
    send(8'hBE); send(8'h01); send(8'h02); send(8'h03);
    send(8'h04); send(8'hFF); send(8'hBD);
    @(negedge clk);
    check("t4_ready_at7", {31'd0, link.noc_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(8'h05);
    @(negedge clk);
    check("t4_ready_full", {31'd0, link.noc_ready}, 32'd0);
    check("t4_hol_valid", {28'd0, link.flit_out_valid}, 32'b0100);
    check("t4_hol_flit", {24'd0, link.flit_out}, 32'hBE);
    @(posedge clk);
    #1;
    link.flit_in       = 8'hFF;
    link.flit_in_valid = 1'b1;
    link.dest_ready    = 4'hF;
    @(negedge clk);
    check("t4_ready_pop_cycle", {31'd0, link.noc_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_ready_after_pop", {31'd0, link.noc_ready}, 32'd1);
    @(posedge clk);
    #1;
    link.flit_in_valid = 1'b0;
    drain();
    check("t4_pkt", {24'd0, pkt_cnt}, 32'd6);

    // 5: reset mid-packet discards buffered flits and counters
    link.dest_ready = 4'h0;
    send(8'hBE); send(8'h01); send(8'h02);
    @(negedge clk);
    check("t5_pre_valid", {28'd0, link.flit_out_valid}, 32'b0100);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("t5_valid", {28'd0, link.flit_out_valid}, 32'd0);
    check("t5_flit", {24'd0, link.flit_out}, 32'd0);
    check("t5_ready", {31'd0, link.noc_ready}, 32'd1);
    check("t5_pkt", {24'd0, pkt_cnt}, 32'd0);
    check("t5_err", {24'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    link.dest_ready = 4'hF;
    expect_flit(3, 8'hBF); expect_flit(3, 8'hAB); expect_flit(3, 8'hFF);
    send(8'hBF); send(8'hAB); send(8'hFF);
    drain();
    check("t5_pkt_after", {24'd0, pkt_cnt}, 32'd1);

    // 6: four data flits force the next flit to be the tail, flagged as an error
    do_reset();
    expect_flit(3, 8'hBF); expect_flit(3, 8'h01); expect_flit(3, 8'h02);
    expect_flit(3, 8'h03); expect_flit(3, 8'h04); expect_flit(3, 8'h5A);
    send(8'hBF); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h5A);
    drain();
    check("t6_pkt", {24'd0, pkt_cnt}, 32'd1);
    check("t6_err", {24'd0, err_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
